// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, the default operand width and a counter-width helper.
package div_pkg;

  // Default operand/result width.
  localparam int DIV_WIDTH_DEFAULT = 4;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Bits needed to hold an iteration count of w-1 (never below one bit).
  function automatic int div_cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted
// partial remainder; keep the difference on no borrow, otherwise restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   shifted_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Trial subtract at WIDTH+1 bits. The divisor never exceeds WIDTH bits,
  // so a set top bit of the shifted remainder already guarantees no borrow;
  // otherwise the top bit of the difference is the borrow.
  always_comb begin
    diff     = shifted_rem - {1'b0, divisor};
    q_bit    = shifted_rem[WIDTH] | ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider (IDLE -> RUN for WIDTH cycles -> DONE).
// Optional macro DIV_ZERO_DETECT_EN adds a div_zero output and short-circuits
// a zero divisor to DONE after a single RUN cycle.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic             div_zero
`endif
);

  localparam int             CW       = div_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;          // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;          // captured divisor
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             div_zero_q, div_zero_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .shifted_rem({rem_q, dvd_q[WIDTH-1]}),
    .divisor    (dvs_q),
    .rem_next   (step_rem),
    .q_bit      (step_qbit)
  );

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    div_zero_d  = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Dividend shifts out at the MSB while quotient bits enter at the LSB.
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {dvd_q[WIDTH-2:0], step_qbit};
          remainder_d = step_rem;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`ifdef DIV_ZERO_DETECT_EN
        // A zero divisor is caught on the first RUN cycle, while dvd_q still
        // holds the untouched dividend.
        if (dvs_q == '0) begin
          state_d     = DONE;
          cnt_d       = '0;
          quotient_d  = '1;
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = div_zero_q;
`endif

endmodule : seq_restoring_divider
